load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 25 ++
 rtl/load_store_unit_load_align.sv | 32 +++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared core constants for the load/store path.
//   SIZE_*  : access-size encodings carried on ex_size (3 is reserved and
//             is handled as a word access).
//   STATE_* : load_store_unit FSM encodings.
//   is_misaligned() : natural-alignment test for a (size, address[1:0]) pair.
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_ACCESS = 2'd1;
  localparam logic [1:0] STATE_HOLD   = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the addressed byte/half lane out of a 32-bit bus word and
// sign- or zero-extends it to 32 bits.
//   rdata         : raw word from the data bus
//   offset        : byte offset of the access inside the word
//   size          : SIZE_B / SIZE_H / SIZE_W (anything else is a word)
//   unsigned_load : 1 = zero-extend (LBU/LHU), 0 = sign-extend
//   data          : aligned, extended load result
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  output logic [31:0] data
);

  logic [31:0] lane;

  // NOTE: every output of a combinational block gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    lane = rdata >> {offset, 3'b000};
    data = rdata;
    case (size)
      SIZE_B:  data = {{24{~unsigned_load & lane[7]}}, lane[7:0]};
      SIZE_H:  data = {{16{~unsigned_load & lane[15]}}, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sits between execute and writeback. Pass-through ops go to
// writeback with one cycle of latency; loads and stores perform one data-bus
// transaction (IDLE -> ACCESS -> HOLD -> IDLE) and then write back.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   ex_*                          : op from execute (valid/ready handshake)
//   mem_valid/ready/write/addr,
//   mem_wdata/wstrb, mem_rdata    : word-addressed data bus
//   wb_valid/ready, wb_data/rd,
//   wb_write, wb_misaligned       : writeback payload (valid/ready handshake)
// MISALIGN_TRAP = 1 reports misaligned accesses without touching the bus;
// MISALIGN_TRAP = 0 ignores the offending low address bits.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MISALIGN_TRAP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_rd,
  input  logic        ex_write_reg,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_write,
  output logic        wb_misaligned
);

  logic [1:0]  state;
  logic [1:0]  offset_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        load_q;
  logic        write_q;

  logic        is_mem;
  logic        misaligned;
  logic [1:0]  size_eff;
  logic [1:0]  offset_eff;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [31:0] load_data;

  // Both kind bits set is illegal and falls back to pass-through.
  assign is_mem     = ex_load ^ ex_store;
  assign size_eff   = (ex_size == 2'd3) ? SIZE_W : ex_size;
  assign misaligned = (MISALIGN_TRAP != 0) && is_misaligned(size_eff, ex_result[1:0]);
  assign ex_ready   = (state == STATE_IDLE) && (!wb_valid || wb_ready);

  always_comb begin
    offset_eff = 2'b00;
    strb       = 4'b1111;
    wdata      = ex_store_data;
    case (size_eff)
      SIZE_B: begin
        offset_eff = ex_result[1:0];
        strb       = 4'b0001 << ex_result[1:0];
        wdata      = {4{ex_store_data[7:0]}};
      end
      SIZE_H: begin
        // Without the trap the offending bit 0 is simply dropped.
        offset_eff = {ex_result[1], 1'b0};
        strb       = 4'b0011 << {ex_result[1], 1'b0};
        wdata      = {2{ex_store_data[15:0]}};
      end
      default: begin
        offset_eff = 2'b00;
        strb       = 4'b1111;
        wdata      = ex_store_data;
      end
    endcase
  end

  load_align u_load_align (
    .rdata         (mem_rdata),
    .offset        (offset_q),
    .size          (size_q),
    .unsigned_load (unsigned_q),
    .data          (load_data)
  );

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= STATE_IDLE;
      offset_q      <= 2'b00;
      size_q        <= SIZE_W;
      unsigned_q    <= 1'b0;
      load_q        <= 1'b0;
      write_q       <= 1'b0;
      mem_valid     <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= 4'b0000;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_write      <= 1'b0;
      wb_misaligned <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (wb_valid && wb_ready) wb_valid <= 1'b0;
          if (ex_valid && ex_ready) begin
            wb_rd <= ex_rd;
            if (!is_mem) begin
              wb_valid      <= 1'b1;
              wb_data       <= ex_result;
              wb_write      <= ex_write_reg;
              wb_misaligned <= 1'b0;
            end else if (misaligned) begin
              // Faulting address is reported as the payload.
              wb_valid      <= 1'b1;
              wb_data       <= ex_result;
              wb_write      <= 1'b0;
              wb_misaligned <= 1'b1;
            end else begin
              state      <= STATE_ACCESS;
              mem_valid  <= 1'b1;
              mem_write  <= ex_store;
              mem_addr   <= {ex_result[31:2], 2'b00};
              mem_wdata  <= wdata;
              mem_wstrb  <= ex_store ? strb : 4'b0000;
              offset_q   <= offset_eff;
              size_q     <= size_eff;
              unsigned_q <= ex_unsigned;
              load_q     <= ex_load;
              write_q    <= ex_load & ex_write_reg;
            end
          end
        end
        STATE_ACCESS: begin
          // Request fields stay frozen until the bus accepts.
          if (mem_ready) begin
            state         <= STATE_HOLD;
            mem_valid     <= 1'b0;
            mem_write     <= 1'b0;
            mem_wstrb     <= 4'b0000;
            wb_valid      <= 1'b1;
            wb_data       <= load_q ? load_data : '0;
            wb_write      <= write_q;
            wb_misaligned <= 1'b0;
          end
        end
        STATE_HOLD: begin
          if (wb_ready) begin
            state    <= STATE_IDLE;
            wb_valid <= 1'b0;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. A behavioural model executes every
// accepted op against a byte-level memory image and predicts the bus request
// and the writeback payload; directed ops cover the documented corner cases,
// then a randomized stream with random back-pressure follows.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_load = 1'b0;
  logic        ex_store = 1'b0;
  logic [1:0]  ex_size = '0;
  logic        ex_unsigned = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_write_reg = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_write;
  logic        wb_misaligned;

  load_store_unit #(.MISALIGN_TRAP(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_load(ex_load), .ex_store(ex_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd),
    .ex_write_reg(ex_write_reg),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_write(wb_write), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ld, st, uns, we;
    bit [1:0]  size;
    bit [31:0] res, sd;
    bit [4:0]  rd;
  } op_t;

  typedef struct {
    bit [31:0] data;
    bit [4:0]  rd;
    bit        we, mis, chk_data, is_mem;
  } wb_t;

  typedef struct {
    bit [31:0] addr, wdata;
    bit        wr;
    bit [3:0]  strb;
  } bus_t;

  int checks = 0;
  int errors = 0;

  op_t  opq[$];
  wb_t  wbq[$];
  bus_t busq[$];
  bit [31:0] mem_model [256];

  op_t cur;
  bit  cur_valid = 1'b0;
  bit  bus_done  = 1'b0;
  bit  rand_mode = 1'b0;
  int  ex_pct = 100, mem_pct = 100, wb_pct = 100;
  int  accepted = 0, retired = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic op_t mk(input bit ld, input bit st, input bit [1:0] size,
                             input bit uns, input bit [31:0] res, input bit [31:0] sd);
    op_t o;
    o.ld = ld; o.st = st; o.size = size; o.uns = uns; o.res = res; o.sd = sd;
    o.rd = 5'($urandom_range(1, 31)); o.we = 1'b1;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int kind;
    kind   = $urandom_range(0, 3);
    o.ld   = kind[0];
    o.st   = kind[1];
    o.size = 2'($urandom_range(0, 3));
    o.uns  = 1'($urandom_range(0, 1));
    o.res  = (o.ld ^ o.st) ? 32'($urandom_range(0, 1023)) : $urandom();
    o.sd   = $urandom();
    o.rd   = 5'($urandom_range(0, 31));
    o.we   = 1'($urandom_range(0, 1));
    return o;
  endfunction

  // Reference semantics of one op, executed at acceptance.
  task automatic model_accept(input op_t o);
    wb_t  w;
    bus_t b;
    int   nbytes, off, idx;
    bit [31:0] word, val;
    w = '{data: 0, rd: o.rd, we: 0, mis: 0, chk_data: 0, is_mem: 0};
    nbytes = (o.size == 0) ? 1 : (o.size == 1) ? 2 : 4;
    off    = int'(o.res[1:0]);
    idx    = int'(o.res[9:2]);
    if (o.ld == o.st) begin
      w.data = o.res; w.we = o.we; w.chk_data = 1;
    end else if (off % nbytes != 0) begin
      w.mis = 1;
    end else begin
      w.is_mem = 1;
      b.addr = o.res & 32'hFFFF_FFFC;
      b.wr   = o.st;
      b.strb = '0;
      b.wdata = '0;
      word   = mem_model[idx];
      if (o.st) begin
        for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = o.sd[8*(i % nbytes) +: 8];
        for (int k = 0; k < nbytes; k++) begin
          b.strb[off+k] = 1'b1;
          word[8*(off+k) +: 8] = o.sd[8*k +: 8];
        end
        mem_model[idx] = word;
      end else begin
        val = 0;
        for (int k = 0; k < nbytes; k++) val[8*k +: 8] = word[8*(off+k) +: 8];
        if (!o.uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~((32'd1 << (8*nbytes)) - 1);
        w.data = val; w.we = o.we; w.chk_data = 1;
      end
      busq.push_back(b);
    end
    wbq.push_back(w);
    accepted++;
  endtask

  // One clock: drive at the falling edge, sample 1 ns later, then advance the model.
  task automatic step();
    bit exp_wbv, busy, exp_rdy;
    @(negedge clk);
    wb_ready  = ($urandom_range(0, 99) < wb_pct);
    mem_ready = ($urandom_range(0, 99) < mem_pct);
    mem_rdata = (busq.size() > 0) ? mem_model[busq[0].addr[9:2]] : $urandom();
    if (!cur_valid && $urandom_range(0, 99) < ex_pct) begin
      if (opq.size() > 0) begin cur = opq.pop_front(); cur_valid = 1'b1; end
      else if (rand_mode) begin cur = rand_op(); cur_valid = 1'b1; end
    end
    ex_valid      = cur_valid;
    ex_load       = cur.ld;
    ex_store      = cur.st;
    ex_size       = cur.size;
    ex_unsigned   = cur.uns;
    ex_result     = cur.res;
    ex_store_data = cur.sd;
    ex_rd         = cur.rd;
    ex_write_reg  = cur.we;
    #1;
    busy = 1'b0;
    foreach (wbq[i]) if (wbq[i].is_mem) busy = 1'b1;
    exp_wbv = (wbq.size() > 0) && (!wbq[0].is_mem || bus_done);
    exp_rdy = !busy && (!exp_wbv || wb_ready);
    check("ex_ready", ex_ready, exp_rdy);
    check("wb_valid", wb_valid, exp_wbv);
    if (wb_valid && exp_wbv) begin
      check("wb_rd", wb_rd, wbq[0].rd);
      check("wb_write", wb_write, wbq[0].we);
      check("wb_misaligned", wb_misaligned, wbq[0].mis);
      if (wbq[0].chk_data) check("wb_data", wb_data, wbq[0].data);
    end
    check("mem_valid", mem_valid, busq.size() > 0);
    if (mem_valid && busq.size() > 0) begin
      check("mem_addr", mem_addr, busq[0].addr);
      check("mem_write", mem_write, busq[0].wr);
      check("mem_wstrb", mem_wstrb, busq[0].strb);
      if (busq[0].wr) check("mem_wdata", mem_wdata, busq[0].wdata);
    end
    if (exp_wbv && wb_ready) begin
      if (wbq[0].is_mem) bus_done = 1'b0;
      void'(wbq.pop_front());
      retired++;
    end
    if (busq.size() > 0 && mem_ready) begin
      void'(busq.pop_front());
      bus_done = 1'b1;
    end
    if (cur_valid && exp_rdy) begin
      model_accept(cur);
      cur_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    ex_pct = 100; mem_pct = 100; wb_pct = 100;
    for (int i = 0; i < 200 && (opq.size() > 0 || cur_valid || wbq.size() > 0); i++) step();
    check("drained_ops", opq.size() + int'(cur_valid), 0);
    check("drained_wb", wbq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom();
    cur = mk(0, 0, 0, 0, 0, 0);

    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_wb_misaligned", wb_misaligned, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Signed/unsigned byte loads from the top lane, half store to the upper
    // half, misaligned word load.
    mem_model[8'h40] = 32'h80FF_0000;
    opq.push_back(mk(1, 0, 0, 0, 32'h103, 0));
    opq.push_back(mk(1, 0, 0, 1, 32'h103, 0));
    opq.push_back(mk(0, 1, 1, 0, 32'h202, 32'h1234_ABCD));
    opq.push_back(mk(1, 0, 1, 0, 32'h202, 0));
    opq.push_back(mk(1, 0, 2, 0, 32'h101, 0));
    opq.push_back(mk(1, 1, 2, 0, 32'hDEAD_BEEF, 0));
    drain();

    // Bus stall for 5 cycles with a pass-through op queued behind the load.
    mem_pct = 0;
    opq.push_back(mk(1, 0, 2, 0, 32'h3F0, 0));
    opq.push_back(mk(0, 0, 0, 0, 32'hCAFE_F00D, 0));
    run(6);
    drain();

    // Writeback back-pressure for 3 cycles during a pass-through stream.
    for (int i = 0; i < 6; i++) opq.push_back(mk(0, 0, 0, 0, 32'h1000 + 32'(i), 0));
    run(2);
    wb_pct = 0;
    run(3);
    drain();

    // Random stream with random handshakes on all three interfaces.
    rand_mode = 1'b1;
    ex_pct = 70; mem_pct = 50; wb_pct = 60;
    run(3000);
    rand_mode = 1'b0;
    drain();
    check("ops_retired", retired, accepted);

    // Reset pulse in the middle of a stalled load.
    mem_pct = 0;
    opq.push_back(mk(1, 0, 2, 0, 32'h80, 0));
    run(3);
    check("pre_reset_mem_valid", mem_valid, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_mem_valid", mem_valid, 0);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_idle", ex_ready, 1);
    wbq.delete();
    busq.delete();
    bus_done  = 1'b0;
    cur_valid = 1'b0;
    ex_valid  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ex_pct = 0; mem_pct = 100; wb_pct = 100;
    run(4);
    opq.push_back(mk(0, 0, 0, 0, 32'h5A5A_5A5A, 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
